// File: rtl/ct_mod_cascade_pkg.sv
// Shared types and defaults for the cascaded modulo counter (package ct_pkg).
package ct_pkg;

  typedef enum logic {CT_UP = 1'b0, CT_DOWN = 1'b1} dir_e;

  localparam int STAGES_DEF = 4;
  localparam int WIDTH_DEF  = 7;

  // Stage-select width, never below one bit so a single-stage build still has a port.
  function automatic int sel_width(input int stages);
    return (stages > 1) ? $clog2(stages) : 1;
  endfunction

endpackage

// File: rtl/ct_mod_cascade_if.sv
// Bus bundle between the cascade counter and its user (alarm/display side).
interface ct_mod_cascade_if #(
  parameter int STAGES = ct_pkg::STAGES_DEF,
  parameter int WIDTH  = ct_pkg::WIDTH_DEF
);
  import ct_pkg::*;

  localparam int SEL_W = sel_width(STAGES);

  logic                          en;
  dir_e                          dir;
  logic [STAGES-1:0][WIDTH-1:0]  modulus;
  logic                          ld;
  logic [SEL_W-1:0]              ld_sel;
  logic [WIDTH-1:0]              ld_val;
  logic [STAGES-1:0][WIDTH-1:0]  ct_out;
  logic [STAGES-1:0]             z;
  logic                          carry_out;

  modport master (
    output en, dir, modulus, ld, ld_sel, ld_val,
    input  ct_out, z, carry_out
  );

  modport slave (
    input  en, dir, modulus, ld, ld_sel, ld_val,
    output ct_out, z, carry_out
  );

endinterface

// File: rtl/ct_mod_cascade_stage.sv
// One modulo counter stage with run-time modulus, load clamp and terminal flag.
// Down counting is only built when CT_CASCADE_DOWN_EN is defined.
module ct_stage
  import ct_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  dir_e             dir,
  input  logic [WIDTH-1:0] modulus,
  input  logic             ld_hit,
  input  logic [WIDTH-1:0] ld_val,
  output logic [WIDTH-1:0] ct,
  output logic             z
);

  localparam int XW = WIDTH + 1;

  logic [WIDTH-1:0] ct_d, ct_q;
  logic [WIDTH-1:0] top_s, term_s, ld_clamp_s, up_nxt_s, step_nxt_s;
  logic             degen_s;
  dir_e             dir_eff_s;

`ifdef CT_CASCADE_DOWN_EN
  logic [WIDTH-1:0] dn_nxt_s;
  assign dir_eff_s = dir;
`else
  logic dir_unused;
  assign dir_unused = dir;
  assign dir_eff_s  = CT_UP;
`endif

  // Compares run one bit wider so modulus = 2^WIDTH-1 cannot overflow.
  always_comb begin
    degen_s    = ({1'b0, modulus} <= XW'(1));
    top_s      = degen_s ? {WIDTH{1'b0}} : (modulus - WIDTH'(1));
    term_s     = (dir_eff_s == CT_DOWN) ? {WIDTH{1'b0}} : top_s;
    ld_clamp_s = ({1'b0, ld_val} < {1'b0, modulus}) ? ld_val : top_s;
    up_nxt_s   = ({1'b0, ct_q} >= {1'b0, top_s}) ? {WIDTH{1'b0}} : (ct_q + WIDTH'(1));
`ifdef CT_CASCADE_DOWN_EN
    // A count left above a shrunken modulus restarts from the top on the next advance.
    if ((ct_q == {WIDTH{1'b0}}) || ({1'b0, ct_q} >= {1'b0, modulus})) begin
      dn_nxt_s = top_s;
    end else begin
      dn_nxt_s = ct_q - WIDTH'(1);
    end
    step_nxt_s = (dir_eff_s == CT_DOWN) ? dn_nxt_s : up_nxt_s;
`else
    step_nxt_s = up_nxt_s;
`endif
  end

  // Next count: load wins over advance; otherwise hold.
  always_comb begin
    ct_d = ct_q;
    if (ld_hit) begin
      ct_d = ld_clamp_s;
    end else if (adv) begin
      ct_d = step_nxt_s;
    end else begin
      ct_d = ct_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ct_q <= {WIDTH{1'b0}};
    end else begin
      ct_q <= ct_d;
    end
  end

  assign ct = ct_q;
  assign z  = (ct_q == term_s);

endmodule

// File: rtl/ct_mod_cascade.sv
// Cascade of modulo counter stages (e.g. sec/min/hr/day) with per-stage load.
// Optional down counting: define CT_CASCADE_DOWN_EN.
module ct_mod_cascade
  import ct_pkg::*;
#(
  parameter int STAGES = STAGES_DEF,
  parameter int WIDTH  = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  ct_mod_cascade_if.slave  bus
);

  localparam int SEL_W = sel_width(STAGES);

  logic [STAGES-1:0]            adv_s;
  logic [STAGES-1:0]            ld_hit_s;
  logic [STAGES-1:0]            z_s;
  logic [STAGES-1:0][WIDTH-1:0] ct_s;

  // Ripple enable: a stage moves only when every lower stage is terminal.
  always_comb begin
    adv_s    = '0;
    adv_s[0] = bus.en & ~bus.ld;
    for (int i = 1; i < STAGES; i++) begin
      adv_s[i] = adv_s[i-1] & z_s[i-1];
    end
  end

  // Load decode; an out-of-range select writes nothing but still blocks counting.
  always_comb begin
    ld_hit_s = '0;
    for (int i = 0; i < STAGES; i++) begin
      ld_hit_s[i] = bus.ld & (bus.ld_sel == SEL_W'(i));
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    ct_stage #(.WIDTH(WIDTH)) u_stage (
      .clk     (clk),
      .rst     (rst),
      .adv     (adv_s[g]),
      .dir     (bus.dir),
      .modulus (bus.modulus[g]),
      .ld_hit  (ld_hit_s[g]),
      .ld_val  (bus.ld_val),
      .ct      (ct_s[g]),
      .z       (z_s[g])
    );
  end

  assign bus.ct_out    = ct_s;
  assign bus.z         = z_s;
  assign bus.carry_out = bus.en & ~bus.ld & (&z_s);

endmodule
